// File: rtl/rr_bus_arbiter_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arb_pkg;

    localparam int N_MASTERS = 3;

    typedef logic [N_MASTERS-1:0] arb_vector;

    localparam arb_vector NO_REQUEST = '0;
    localparam arb_vector NO_GRANT   = '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface rr_bus_arbiter_if #(
    parameter int N_MASTERS = bus_arb_pkg::N_MASTERS
);
    localparam int ID_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [N_MASTERS-1:0] bus_req;
    logic                 bus_ack;
    logic                 bus_lock;
    logic [N_MASTERS-1:0] bus_grant;
    logic [ID_W-1:0]      grant_id;
    logic                 timeout_err;

    modport master (
        output bus_req, bus_ack, bus_lock,
        input  bus_grant, grant_id, timeout_err
    );

    modport slave (
        input  bus_req, bus_ack, bus_lock,
        output bus_grant, grant_id, timeout_err
    );

endinterface

// File: rtl/rr_bus_arbiter_pick.sv
// Combinational round-robin pick: first set request strictly above ptr, wrapping.
module rr_pick #(
    parameter int N_MASTERS = 3,
    localparam int ID_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [ID_W-1:0]      ptr,
    output logic [N_MASTERS-1:0] winner,
    output logic [ID_W-1:0]      winner_id,
    output logic                 any_req
);

    int idx;

    always_comb begin
        winner    = '0;
        winner_id = '0;
        any_req   = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = (int'(ptr) + k) % N_MASTERS;
            if (!any_req && req[idx]) begin
                any_req     = 1'b1;
                winner[idx] = 1'b1;
                winner_id   = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with lock support and per-grant ack timeout.
module rr_bus_arbiter #(
    parameter int N_MASTERS      = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic             clk,
    input logic             reset,
    rr_bus_arbiter_if.slave bus
);
    import bus_arb_pkg::arb_state_t;
    import bus_arb_pkg::IDLE;
    import bus_arb_pkg::BUSY;

    localparam int ID_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(N_MASTERS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic [N_MASTERS-1:0] win;
    logic [ID_W-1:0]      win_id;
    logic                 any_req;

    rr_pick #(.N_MASTERS(N_MASTERS)) u_pick (
        .req       (bus.bus_req),
        .ptr       (ptr_q),
        .winner    (win),
        .winner_id (win_id),
        .any_req   (any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= PTR_INIT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    grant_d = win;
                    id_d    = win_id;
                    ptr_d   = win_id;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // ack beats a coincident timeout; a locked owner keeps the bus
                if (bus.bus_ack) begin
                    cnt_d = '0;
                    if (!(bus.bus_lock && bus.bus_req[id_q])) begin
                        if (any_req) begin
                            grant_d = win;
                            id_d    = win_id;
                            ptr_d   = win_id;
                        end else begin
                            state_d = IDLE;
                            grant_d = '0;
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.bus_grant   = grant_q;
    assign bus.grant_id    = id_q;
    assign bus.timeout_err = err_q;

    a_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));
    a_hold   : assert property (@(posedge clk) disable iff (reset)
        (state_q == BUSY && !bus.bus_ack && cnt_q != CNT_LAST) |=> $stable(grant_q));
    a_pulse  : assert property (@(posedge clk) disable iff (reset) err_q |=> !err_q);

endmodule

// File: doc/rr_bus_arbiter.md
RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

Interface
REQ-001 The module SHALL have parameter N_MASTERS, default 3, giving the number of requesting masters.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum BUSY cycles without bus_ack before a grant is revoked.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The module SHALL have port bus_req, input, N_MASTERS bits, with bit i as master i's request.
REQ-006 The module SHALL have port bus_ack, input, 1 bit, meaning the current owner's transfer is complete.
REQ-007 The module SHALL have port bus_lock, input, 1 bit, meaning the current owner keeps the bus across bus_ack.
REQ-008 The module SHALL have port bus_grant, output, N_MASTERS bits, a one-hot or all-zero grant.
REQ-009 The module SHALL have port grant_id, output, $clog2(N_MASTERS) bits, the index of the granted master, valid while bus_grant is non-zero.
REQ-010 The module SHALL have port timeout_err, output, 1 bit, a one-cycle pulse on grant revocation by timeout.

Function
REQ-011 bus_grant SHALL be registered, with at most one bit set in every cycle.
REQ-012 States SHALL be IDLE (no grant) and BUSY (exactly one grant).
REQ-013 In IDLE with bus_req non-zero, the arbiter SHALL set the round-robin winner's grant bit at the next edge and enter BUSY, giving 1-cycle latency.
REQ-014 Round-robin winner: the first set bus_req bit searching upward from ptr+1 modulo N_MASTERS; ptr is the index of the last granted master.
REQ-015 Each new grant SHALL load ptr with the winner's index.
REQ-016 In BUSY with bus_ack low and no timeout, bus_grant, grant_id and ptr SHALL hold stable, even if the owner drops its request.
REQ-017 BUSY with bus_ack high, bus_lock high and the owner's request high: the grant SHALL be kept and the timeout counter cleared.
REQ-018 BUSY with bus_ack high otherwise: the arbiter SHALL regrant the round-robin winner next cycle, and may regrant the same master if it is the sole requester.
REQ-019 BUSY with bus_ack high and bus_req zero: bus_grant SHALL go to zero and the state to IDLE.
REQ-020 The timeout counter SHALL clear on entering BUSY and on every bus_ack, and increment each BUSY cycle without bus_ack.
REQ-021 When the counter equals TIMEOUT_CYCLES-1 with bus_ack low, the next edge SHALL clear bus_grant, pulse timeout_err for one cycle and enter IDLE.
REQ-022 After a timeout, ptr SHALL keep the timed-out master's index, so that master has lowest priority next.
REQ-023 bus_ack in the same cycle as the timeout condition SHALL take precedence, with normal completion and no timeout_err.
REQ-024 bus_ack and bus_lock SHALL be ignored in IDLE.
REQ-025 The counter width SHALL be $clog2(TIMEOUT_CYCLES)+1 and SHALL never wrap.

Reset
REQ-026 On reset, the next edge SHALL set bus_grant=0, grant_id=0, timeout_err=0, state=IDLE, counter=0, ptr=N_MASTERS-1, so master 0 wins first.
REQ-027 Reset asserted mid-transfer SHALL revoke the grant at that edge without raising timeout_err.
REQ-028 Requests SHALL be arbitrated normally from the first edge after reset deasserts.

Structure
REQ-029 Package bus_arb_pkg SHALL hold N_MASTERS, typedef arb_vector, NO_REQUEST, NO_GRANT and the state enum.
REQ-030 A combinational sub-module rr_pick SHALL map (bus_req, ptr) to a one-hot winner and its index.
REQ-031 The FSM, ptr and counter SHALL reside in rr_bus_arbiter.

Verification
REQ-032 Reset then bus_req=3'b111, ack every 2 cycles -> grants 001,010,100,001 in turn.
REQ-033 Owner master 1, bus_req=3'b011, bus_ack=1, bus_lock=1 -> bus_grant stays 3'b010; bus_lock=0 with ack -> 3'b001 next.
REQ-034 Grant 3'b100, no bus_ack for 16 cycles -> timeout_err high one cycle, bus_grant=0, then with bus_req=3'b101 next grant 3'b001.
REQ-035 bus_ack coincident with cycle 15 of BUSY -> no timeout_err, normal regrant.
REQ-036 Reset asserted while grant=3'b010 -> bus_grant=0 at that edge, then bus_req=3'b110 -> grant 3'b010 (ptr=2 start).
REQ-037 Assertions on every cycle: $onehot0(bus_grant); bus_grant stable when non-zero and bus_ack low before timeout; timeout_err never high two consecutive cycles.
